// File: rtl/acc_alu_seq.sv
// Accumulator/extend-flag ALU: one register-reference op per valid/ready handshake.
// Rotates through E run one bit per cycle in the SHIFT state.
module acc_alu_seq #(
    parameter int N     = 16,
    parameter int INP_W = 8,
    parameter int SH_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [N-1:0]     dr,
    input  logic [INP_W-1:0] inp,
    input  logic [SH_W-1:0]  shamt,
    output logic [N-1:0]     ac,
    output logic             e,
    output logic             zero,
    output logic             neg,
    output logic             done,
    output logic             illegal
);
    // state | meaning
    // IDLE  | accepting ops; single-cycle ops complete here
    // SHIFT | rotating {AC,E} one bit per cycle until cnt reaches 1
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [3:0] OP_NOP = 4'd0,  OP_AND = 4'd1,  OP_ADD = 4'd2,  OP_LDA = 4'd3;
    localparam logic [3:0] OP_INP = 4'd4,  OP_CMA = 4'd5,  OP_CIR = 4'd6,  OP_CIL = 4'd7;
    localparam logic [3:0] OP_CLA = 4'd8,  OP_CLE = 4'd9,  OP_CME = 4'd10, OP_INC = 4'd11;
    localparam logic [3:0] OP_ADC = 4'd12, OP_SUB = 4'd13;

    state_t          state;
    logic [SH_W-1:0] cnt;
    logic            dir_left;
    logic            accept;
    logic [N:0]      sum_add;
    logic [N:0]      sum_adc;
    logic [N:0]      sum_sub;

    assign op_ready = (state == IDLE);
    assign accept   = op_valid & op_ready;
    assign zero     = (ac == '0);
    assign neg      = ac[N-1];

    // Carry out lands in bit N and becomes the new E.
    assign sum_add = {1'b0, ac} + {1'b0, dr};
    assign sum_adc = sum_add + {{N{1'b0}}, e};
    assign sum_sub = {1'b0, ac} + {1'b0, ~dr} + {{N{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            ac       <= '0;
            e        <= 1'b0;
            state    <= IDLE;
            cnt      <= '0;
            dir_left <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        done <= 1'b1;
                        case (op_code)
                            OP_NOP: ;
                            OP_AND: ac <= ac & dr;
                            OP_ADD: {e, ac} <= sum_add;
                            OP_LDA: ac <= dr;
                            OP_INP: ac[INP_W-1:0] <= inp;
                            OP_CMA: ac <= ~ac;
                            OP_CIR, OP_CIL: begin
                                if (shamt != '0) begin
                                    done     <= 1'b0;
                                    cnt      <= shamt;
                                    dir_left <= (op_code == OP_CIL);
                                    state    <= SHIFT;
                                end
                            end
                            OP_CLA: ac <= '0;
                            OP_CLE: e <= 1'b0;
                            OP_CME: e <= ~e;
                            OP_INC: ac <= ac + N'(1);
                            OP_ADC: {e, ac} <= sum_adc;
                            OP_SUB: {e, ac} <= sum_sub;
                            default: illegal <= 1'b1;
                        endcase
                    end
                end
                SHIFT: begin
                    if (dir_left) begin
                        ac <= {ac[N-2:0], e};
                        e  <= ac[N-1];
                    end else begin
                        ac <= {e, ac[N-1:1]};
                        e  <= ac[0];
                    end
                    cnt <= cnt - SH_W'(1);
                    if (cnt == SH_W'(1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/acc_alu_seq.md
Name: acc_alu_seq

Overview:
- Parametrised successor to the bit-sliced AC/E adder-logic circuit.
- Holds the accumulator (AC) and extend flip-flop (E) internally and executes one register-reference/ALU operation per valid/ready handshake.
- Adds carry-in add, subtract, increment and clear/complement ops, plus multi-bit rotate through E executed one bit per cycle by an FSM.
- Sits between the control sequencer (issues opcodes) and the common bus (supplies DR and INP; consumes AC).

Parameters:
N, 16, AC/DR width (>=2)
INP_W, 8, input-register width (1..N); loads AC[INP_W-1:0]
SH_W, 5, rotate-amount width (2^SH_W-1 >= N+1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
op_valid  in  1  opcode valid
op_ready  out  1  unit idle, can accept
op_code  in  4  operation select
dr  in  N  data register operand, sampled at accept
inp  in  INP_W  input register, sampled at accept
shamt  in  SH_W  rotate count, sampled at accept
ac  out  N  accumulator
e  out  1  extend flag
zero  out  1  ac==0 (combinational from register)
neg  out  1  ac[N-1]
done  out  1  one-cycle pulse: operation complete
illegal  out  1  one-cycle pulse: reserved opcode accepted

Behaviour:
- Reset (synchronous, active-high): ac=0, e=0, FSM=IDLE, counter=0, done=0, illegal=0, so op_ready=1 and zero=1. rst has priority over acceptance; rst during SHIFT aborts the rotate with no done pulse.
- Accept = op_valid & op_ready. op_ready=1 exactly in IDLE. op_valid while busy is ignored and not queued.
- Single-cycle ops update AC/E at the accept edge. done=1 in the following cycle. op_ready stays 1, so back-to-back issue is allowed every cycle.
- Opcodes (arithmetic is modulo 2^N; E unchanged unless stated):
  - 0 NOP.
  - 1 AND: AC&=DR.
  - 2 ADD: {E,AC}=AC+DR.
  - 3 LDA: AC=DR.
  - 4 INP: AC[INP_W-1:0]=inp; upper bits unchanged.
  - 5 CMA: AC=~AC.
  - 6 CIR: rotate {AC,E} right.
  - 7 CIL: rotate left.
  - 8 CLA: AC=0.
  - 9 CLE: E=0.
  - 10 CME: E=~E.
  - 11 INC: AC=AC+1 (wraps, E unchanged).
  - 12 ADC: {E,AC}=AC+DR+E.
  - 13 SUB: {E,AC}=AC+~DR+1 (E=1 means no borrow).
  - 14,15 reserved: no state change, illegal=1 and done=1 in the next cycle.
- Rotate (CIR/CIL), shamt=k:
  - k=0: behaves as single-cycle NOP (done next cycle).
  - k>0, at the accept edge: cnt<=k, dir latched, FSM->SHIFT, AC/E unchanged.
  - Each SHIFT edge performs one step and decrements cnt:
    - CIR step: AC<={E,AC[N-1:1]}, E<=AC[0].
    - CIL step: AC<={AC[N-2:0],E}, E<=AC[N-1].
  - On the edge where cnt==1: FSM->IDLE, done<=1.
  - op_ready is low for exactly k cycles after accept; done and op_ready=1 coincide in the cycle after the last step.
  - The rotate ring is N+1 bits, so k=N+1 restores the original {AC,E}.
- done and illegal are registered, high for exactly one cycle, and never both asserted for a valid op.

Test Plan:
1. N=8. Assert rst 2 cycles -> ac=0x00, e=0, zero=1, op_ready=1, done=0.
2. LDA dr=0xF0, then ADD dr=0x20 on consecutive cycles -> ac=0xF0, then ac=0x10, e=1; done high in each following cycle; op_ready never drops.
3. e=1, ac=0x01, ADC dr=0x01 -> ac=0x03, e=0. Then LDA 0x05, SUB dr=0x07 -> ac=0xFE, e=0, neg=1. Then INC x2 -> ac=0x00, zero=1, e=0.
4. ac=0x81, e=0, CIL shamt=3 -> successive steps (0x02,1), (0x05,0), (0x0A,0). op_ready low 3 cycles; single done pulse. op_valid held during busy is not accepted.
5. ac=0x5A, e=1, CIR shamt=9 -> ac=0x5A, e=1 after 9 busy cycles. Then CIR shamt=0 -> no change, done next cycle, no busy.
6. CIL shamt=5 with rst asserted at step 2 -> ac=0, e=0, op_ready=1 next cycle, no done. Then op_code=15 -> illegal and done pulse once, ac unchanged.
